// File: rtl/draw_polygon_pkg.sv
// Shared types for the polygon outliner: default coordinate width, vertex type, FSM state enum.
package draw_pkg;

  localparam int DRAW_COORD_W = 10;

  typedef logic [1:0][DRAW_COORD_W-1:0] vertex_t;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_LOAD,
    ST_TRIGGER,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } poly_state_t;

endpackage

// File: rtl/draw_polygon_if.sv
// Request/pixel bundle between the vertex stage, draw_polygon and the frame-buffer writer.
interface draw_polygon_if
  import draw_pkg::*;
#(
  parameter int COORD_W   = DRAW_COORD_W,
  parameter int MAX_VERTS = 8,
  parameter int VCNT_W    = $clog2(MAX_VERTS + 1)
);
  // Start is a level request sampled only while idle; Done is held until Start drops.
  // Pixel_Valid has no ready: the writer must take one pixel every cycle it is high.
  logic                                     draw_polygon_Start;
  logic [MAX_VERTS-1:0][1:0][COORD_W-1:0]   Vertices;
  logic [VCNT_W-1:0]                        Num_Verts;
  logic                                     Closed;
  logic [COORD_W-1:0]                       DrawX;
  logic [COORD_W-1:0]                       DrawY;
  logic                                     Pixel_Valid;
  logic                                     Busy;
  logic                                     draw_polygon_Done;

  modport master (
    output draw_polygon_Start, Vertices, Num_Verts, Closed,
    input  DrawX, DrawY, Pixel_Valid, Busy, draw_polygon_Done
  );

  modport slave (
    input  draw_polygon_Start, Vertices, Num_Verts, Closed,
    output DrawX, DrawY, Pixel_Valid, Busy, draw_polygon_Done
  );

endinterface

// File: rtl/draw_polygon_line_walker.sv
// All-octant Bresenham walker: Load latches A/B, each Step advances one pixel, Last flags X/Y == B.
module line_walker #(
  parameter int COORD_W = 10
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Load,
  input  logic [1:0][COORD_W-1:0] A,
  input  logic [1:0][COORD_W-1:0] B,
  input  logic                    Step,
  output logic [COORD_W-1:0]      X,
  output logic [COORD_W-1:0]      Y,
  output logic                    Last
);

  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_q, y_q, bx_q, by_q;
  logic               sx_neg_q, sy_neg_q;
  logic signed [EW-1:0] err_q, dx_q, dy_q;

  logic [COORD_W-1:0]   adx, ady;
  logic signed [EW-1:0] dx_l, dy_l, err_n;
  logic signed [EW:0]   e2;
  logic                 mv_x, mv_y;

  // dx is kept positive and dy negative so one signed error term covers every octant.
  always_comb begin
    adx   = (B[0] >= A[0]) ? B[0] - A[0] : A[0] - B[0];
    ady   = (B[1] >= A[1]) ? B[1] - A[1] : A[1] - B[1];
    dx_l  = signed'({2'b00, adx});
    dy_l  = -signed'({2'b00, ady});
    e2    = signed'({err_q, 1'b0});
    mv_x  = (e2 >= signed'({dy_q[EW-1], dy_q}));
    mv_y  = (e2 <= signed'({dx_q[EW-1], dx_q}));
    err_n = err_q + (mv_x ? dy_q : '0) + (mv_y ? dx_q : '0);
    Last  = (x_q == bx_q) && (y_q == by_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else if (Load) begin
      x_q      <= A[0];
      y_q      <= A[1];
      bx_q     <= B[0];
      by_q     <= B[1];
      sx_neg_q <= (B[0] < A[0]);
      sy_neg_q <= (B[1] < A[1]);
      dx_q     <= dx_l;
      dy_q     <= dy_l;
      err_q    <= dx_l + dy_l;
    end else if (Step) begin
      err_q <= err_n;
      if (mv_x) x_q <= sx_neg_q ? x_q - ONE : x_q + ONE;
      if (mv_y) y_q <= sy_neg_q ? y_q - ONE : y_q + ONE;
    end
  end

  assign X = x_q;
  assign Y = y_q;

endmodule

// File: rtl/draw_polygon.sv
// Polygon/polyline outliner: sequences edges of a latched vertex list through line_walker.
// Build option POLY_SKIP_SHARED_EN suppresses duplicated shared-vertex pixels.
module draw_polygon
  import draw_pkg::*;
#(
  parameter int COORD_W   = DRAW_COORD_W,
  parameter int MAX_VERTS = 8,
  parameter int VCNT_W    = $clog2(MAX_VERTS + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  draw_polygon_if.slave bus,
  output poly_state_t   dbg_state
);

  localparam int IDX_W = $clog2(MAX_VERTS);

  poly_state_t state;
  logic [MAX_VERTS-1:0][1:0][COORD_W-1:0] vert_q;
  logic [VCNT_W-1:0] n_q, e_q, k_q;
  logic              busy_q, done_q, pv_q;

  logic [VCNT_W-1:0]        n_in, k_inc, kb;
  logic [1:0][COORD_W-1:0]  va, vb;
  logic                     wl_load, wl_step, wl_last;
  logic [COORD_W-1:0]       wl_x, wl_y;

  always_comb begin
    n_in    = (bus.Num_Verts > VCNT_W'(MAX_VERTS)) ? VCNT_W'(MAX_VERTS) : bus.Num_Verts;
    k_inc   = k_q + VCNT_W'(1);
    kb      = (k_inc == n_q) ? '0 : k_inc;
    va      = vert_q[k_q[IDX_W-1:0]];
    vb      = vert_q[kb[IDX_W-1:0]];
    wl_load = (state == ST_TRIGGER);
    wl_step = (state == ST_DRAW) && !wl_last;
  end

  line_walker #(.COORD_W(COORD_W)) u_walker (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Load    (wl_load),
    .A       (va),
    .B       (vb),
    .Step    (wl_step),
    .X       (wl_x),
    .Y       (wl_y),
    .Last    (wl_last)
  );

  // Flags are set on the transition into a state so they line up with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= ST_WAIT;
      vert_q <= '0;
      n_q    <= '0;
      e_q    <= '0;
      k_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pv_q   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (bus.draw_polygon_Start) begin
            state  <= ST_LOAD;
            busy_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          vert_q <= bus.Vertices;
          n_q    <= n_in;
          k_q    <= '0;
          // A single vertex still gets one degenerate edge V0->V0.
          if (n_in <= VCNT_W'(1))  e_q <= VCNT_W'(1);
          else if (bus.Closed)     e_q <= n_in;
          else                     e_q <= n_in - VCNT_W'(1);
          if (n_in == '0) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state  <= ST_TRIGGER;
          end
        end
        ST_TRIGGER: begin
          state <= ST_DRAW;
          pv_q  <= 1'b1;
        end
        ST_DRAW: begin
          if (wl_last) begin
            state <= ST_NEXT;
            pv_q  <= 1'b0;
          end
        end
        ST_NEXT: begin
          k_q <= k_inc;
          if (k_inc == e_q) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state  <= ST_TRIGGER;
          end
        end
        ST_DONE: begin
          if (!bus.draw_polygon_Start) begin
            state  <= ST_WAIT;
            done_q <= 1'b0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

`ifdef POLY_SKIP_SHARED_EN
  logic first_q, closed_q, close_last;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      first_q  <= 1'b0;
      closed_q <= 1'b0;
    end else begin
      if (state == ST_LOAD) closed_q <= bus.Closed;
      if (state == ST_TRIGGER)   first_q <= (k_q != '0);
      else if (state == ST_DRAW) first_q <= 1'b0;
    end
  end

  // The closing edge ends on V0, which the first edge already emitted.
  assign close_last      = closed_q && (e_q >= VCNT_W'(2)) && (k_inc == e_q) && wl_last;
  assign bus.Pixel_Valid = pv_q && !first_q && !close_last;
`else
  assign bus.Pixel_Valid = pv_q;
`endif

  assign bus.DrawX             = wl_x;
  assign bus.DrawY             = wl_y;
  assign bus.Busy              = busy_q;
  assign bus.draw_polygon_Done = done_q;
  assign dbg_state             = state;

endmodule

// File: tb/tb_draw_polygon.sv
// Self-checking bench for draw_polygon: Bresenham reference model feeds an expected-pixel queue.
module tb_draw_polygon;
  import draw_pkg::*;

  localparam int CW = 10;
  localparam int MV = 8;
`ifdef POLY_SKIP_SHARED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef logic [MV-1:0][1:0][CW-1:0] vlist_t;
  typedef logic [2*CW-1:0] pix_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  poly_state_t dbg_state;

  draw_polygon_if #(.COORD_W(CW), .MAX_VERTS(MV)) dif ();

  draw_polygon #(.COORD_W(CW), .MAX_VERTS(MV)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .bus       (dif.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   failures = 0;
  pix_t exp_q[$];
  pix_t got_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic pix_t pk(input int x, input int y);
    return {x[CW-1:0], y[CW-1:0]};
  endfunction

  // An unexpected pixel is compared against an all-ones value no test ever draws.
  always @(negedge Clk) begin
    if (Reset_n && dif.Pixel_Valid) begin
      pix_t e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      got_q.push_back({dif.DrawX, dif.DrawY});
      check_val("pixel", {dif.DrawX, dif.DrawY}, e);
    end
  end

  // ---------------- reference model ----------------
  task automatic model_line(input int ax, input int ay, input int bx, input int by,
                            input bit drop_first, input bit drop_last,
                            output int np, output int len);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = (by > ay) ? by - ay : ay - by;
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx - dy;
    len = ((dx > dy) ? dx : dy) + 1;
    x = ax; y = ay; np = 0;
    for (int i = 0; i < len; i++) begin
      if (!((i == 0 && drop_first) || (i == len - 1 && drop_last))) begin
        exp_q.push_back(pk(x, y));
        np++;
      end
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endtask

  task automatic model_poly(input vlist_t v, input int num, input bit closed,
                            output int pix, output int cyc);
    int n, e, np, len, b;
    n = (num > MV) ? MV : num;
    pix = 0;
    cyc = 1;
    if (n == 0) return;
    e = (n == 1) ? 1 : (closed ? n : n - 1);
    for (int k = 0; k < e; k++) begin
      b = (k + 1) % n;
      model_line(int'(v[k][0]), int'(v[k][1]), int'(v[b][0]), int'(v[b][1]),
                 SKIP && (k >= 1), SKIP && closed && (e >= 2) && (k == e - 1), np, len);
      cyc += len + 2;
      pix += np;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_poly(input vlist_t v, input int num, input bit closed, input int hold,
                          output int pix, output int cyc);
    int epix, ecyc, t;
    exp_q.delete();
    got_q.delete();
    model_poly(v, num, closed, epix, ecyc);
    @(negedge Clk);
    dif.Vertices           = v;
    dif.Num_Verts          = 4'(num);
    dif.Closed             = closed;
    dif.draw_polygon_Start = 1'b1;
    t = 0;
    @(negedge Clk);
    while (!dif.Busy && !dif.draw_polygon_Done && t < 20) begin
      @(negedge Clk);
      t++;
    end
    cyc = 0;
    while (!dif.draw_polygon_Done && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        // Latched copies must be used from here on.
        for (int i = 0; i < MV; i++) begin
          dif.Vertices[i][0] = CW'($urandom_range(0, 1023));
          dif.Vertices[i][1] = CW'($urandom_range(0, 1023));
        end
        dif.Num_Verts = 4'($urandom_range(0, 15));
        dif.Closed    = ~closed;
      end
    end
    check_val("done_seen", dif.draw_polygon_Done, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      check_val("done_hold", {dif.draw_polygon_Done, dif.Busy, 1'(dbg_state == ST_DONE)}, 3'b101);
    end
    dif.draw_polygon_Start = 1'b0;
    @(negedge Clk);
    check_val("back_to_wait", {1'(dbg_state == ST_WAIT), dif.draw_polygon_Done}, 2'b10);
    check_val("missing_pixels", exp_q.size(), 0);
    check_val("pixel_count_model", got_q.size(), epix);
    check_val("cycles_model", cyc, ecyc);
    pix = got_q.size();
  endtask

  function automatic int mono_violations();
    int viol = 0;
    for (int i = 1; i < got_q.size(); i++) begin
      if (!(got_q[i][CW-1:0] > got_q[i-1][CW-1:0] && got_q[i][2*CW-1:CW] <= got_q[i-1][2*CW-1:CW]))
        viol++;
    end
    return viol;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    vlist_t v;
    int pix, cyc, mpix, mcyc, t;

    dif.draw_polygon_Start = 1'b0;
    dif.Vertices           = '0;
    dif.Num_Verts          = '0;
    dif.Closed             = 1'b0;
    repeat (3) @(negedge Clk);
    check_val("reset_state", dbg_state, ST_WAIT);
    check_val("reset_outputs", {dif.Busy, dif.draw_polygon_Done, dif.Pixel_Valid, dif.DrawX, dif.DrawY}, 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check_val("idle_no_start", dbg_state, ST_WAIT);

    // Closed triangle
    v = '0;
    v[0][0] = 0; v[0][1] = 0;
    v[1][0] = 4; v[1][1] = 0;
    v[2][0] = 0; v[2][1] = 4;
    run_poly(v, 3, 1'b1, 0, pix, cyc);
    check_val("tri_closed_pixels", pix, SKIP ? 12 : 15);
    check_val("tri_closed_cycles", cyc, 22);
    check_val("tri_closed_first", got_q[0], pk(0, 0));
    check_val("tri_closed_last", got_q[got_q.size()-1], SKIP ? pk(0, 1) : pk(0, 0));

    // Open polyline, same vertices
    run_poly(v, 3, 1'b0, 0, pix, cyc);
    check_val("tri_open_pixels", pix, SKIP ? 9 : 10);
    check_val("tri_open_cycles", cyc, 15);
    check_val("tri_open_last", got_q[got_q.size()-1], pk(0, 4));

    // N = 0
    run_poly(v, 0, 1'b1, 0, pix, cyc);
    check_val("n0_pixels", pix, 0);
    check_val("n0_cycles", cyc, 1);

    // N = 1 at (7,9)
    v[0][0] = 7; v[0][1] = 9;
    run_poly(v, 1, 1'b1, 0, pix, cyc);
    check_val("n1_pixels", pix, 1);
    check_val("n1_cycles", cyc, 4);
    check_val("n1_pixel", got_q[0], pk(7, 9));

    // Steep negative-slope edge
    v[0][0] = 10; v[0][1] = 2;
    v[1][0] = 6;  v[1][1] = 20;
    run_poly(v, 2, 1'b0, 0, pix, cyc);
    check_val("steep_pixels", pix, 19);
    check_val("steep_cycles", cyc, 22);
    check_val("steep_first", got_q[0], pk(10, 2));
    check_val("steep_last", got_q[got_q.size()-1], pk(6, 20));
    check_val("steep_mono", mono_violations(), 0);

    // Closed N=2 retrace, Start held high after Done
    v[0][0] = 3; v[0][1] = 3;
    v[1][0] = 8; v[1][1] = 5;
    run_poly(v, 2, 1'b1, 5, pix, cyc);
    check_val("retrace_pixels", pix, SKIP ? 10 : 12);
    check_val("retrace_cycles", cyc, 1 + 2 * (6 + 2));

    // Asynchronous reset mid-Draw of edge 1
    v = '0;
    v[1][0] = 4; v[2][1] = 4;
    exp_q.delete();
    got_q.delete();
    model_poly(v, 3, 1'b1, mpix, mcyc);
    @(negedge Clk);
    dif.Vertices = v; dif.Num_Verts = 4'd3; dif.Closed = 1'b1;
    dif.draw_polygon_Start = 1'b1;
    t = 0;
    while (got_q.size() < 6 && t < 100) begin
      @(negedge Clk);
      #1;
      t++;
    end
    check_val("rst_reached_edge1", {1'(got_q.size() >= 6), 1'(dbg_state == ST_DRAW)}, 2'b11);
    #1;
    Reset_n = 1'b0;
    dif.draw_polygon_Start = 1'b0;
    #1;
    check_val("rst_async_outputs", {dif.Pixel_Valid, dif.Busy, dif.draw_polygon_Done}, 3'b000);
    check_val("rst_async_state", dbg_state, ST_WAIT);
    exp_q.delete();
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check_val("rst_quiet", {1'(dbg_state == ST_WAIT), dif.Busy, dif.Pixel_Valid, dif.draw_polygon_Done}, 4'b1000);
    end

    // Num_Verts = 9 is clamped to 8; random vertex lists
    for (int r = 0; r < 3; r++) begin
      bit cl;
      for (int i = 0; i < MV; i++) begin
        v[i][0] = CW'($urandom_range(0, 40));
        v[i][1] = CW'($urandom_range(0, 40));
      end
      cl = 1'($urandom_range(0, 1));
      exp_q.delete();
      model_poly(v, 8, cl, mpix, mcyc);
      run_poly(v, 9, cl, 0, pix, cyc);
      check_val("clamp_cycles", cyc, mcyc);
      check_val("clamp_pixels", pix, mpix);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/draw_polygon.md
Name: draw_polygon

Overview:
- Parametrised successor to the fixed three-edge triangle outliner.
- Walks a latched list of up to MAX_VERTS screen-space vertices and rasterises each edge with an internal Bresenham line walker, one pixel per cycle.
- Supports open polylines and closed polygons.
- Sits between the projection/vertex stage and the frame-buffer writer; DrawX/DrawY/Pixel_Valid feed the writer directly.

Parameters:
- COORD_W, 10: width of each unsigned screen coordinate.
- MAX_VERTS, 8: vertex list capacity, must be at least 2.
- VCNT_W, $clog2(MAX_VERTS+1): width of the vertex-count input.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- draw_polygon_Start  in  1  level request; sampled only in Wait.
- Vertices  in  [MAX_VERTS][2][COORD_W]  vertex list; [i][0]=x, [i][1]=y.
- Num_Verts  in  VCNT_W  number of valid vertices.
- Closed  in  1  1 = add closing edge V[N-1]→V[0].
- DrawX  out  COORD_W  current pixel x.
- DrawY  out  COORD_W  current pixel y.
- Pixel_Valid  out  1  DrawX/DrawY is an edge pixel this cycle.
- Busy  out  1  drawing in progress.
- draw_polygon_Done  out  1  completion flag.

Behaviour:
- Reset is asynchronous, active-low. Reset_n low forces state Wait and clears all outputs and internal registers to 0 immediately. This applies mid-edge too: no further pixels are emitted and no Done is produced.
- States: Wait, Load, Trigger, Draw, Next, Done.
- Wait → Load when draw_polygon_Start=1.
- Load (1 cycle):
  - Latches Vertices, Closed, and N = min(Num_Verts, MAX_VERTS).
  - Computes edge count E = Closed ? N : N-1.
  - If N=0 → Done.
  - If N=1: one degenerate edge V0→V0, emitting exactly one pixel.
  - Otherwise edge index k=0, go to Trigger.
- Trigger (1 cycle): loads the line walker with A=V[k] and B=V[(k+1) mod N]. Pixel_Valid=0.
- Draw:
  - Emits one pixel per cycle with Pixel_Valid=1, from A to B inclusive.
  - L = max(|dx|,|dy|)+1 cycles.
  - Standard Bresenham, all octants. The error term is signed, COORD_W+2 bits; no overflow for any COORD_W inputs.
  - On the last pixel → Next.
- Next (1 cycle): k=k+1. If k=E → Done, else → Trigger.
- Done: draw_polygon_Done=1; held until Start=0, then → Wait. Start still high keeps the block in Done, so there is no re-trigger.
- Busy=1 in Load/Trigger/Draw/Next, 0 in Wait/Done.
- DrawX/DrawY hold their last value when Pixel_Valid=0.
- Timing, from the first cycle in Load: 1 + sum over edges of (L_k + 2) cycles until Done.
- Input changes while Busy or Done are ignored; only latched copies are used.
- Closed with N=2 draws V0→V1 then V1→V0 (retrace is permitted).
- Num_Verts > MAX_VERTS is clamped to MAX_VERTS.
- Pixels are produced back-to-back with no backpressure; the downstream writer must accept one pixel per cycle.

Optional Feature:
- Macro POLY_SKIP_SHARED_EN.
- Defined:
  - For edges k≥1, the first pixel (shared vertex) is suppressed: Pixel_Valid=0 for that Draw cycle, cycle count unchanged.
  - If Closed and E≥2, the last pixel of the final edge (V0 again) is also suppressed.
  - Each vertex is emitted exactly once.
- Undefined: every edge emits both endpoints, and shared vertices appear twice.

Decomposition:
- Package draw_pkg holds:
  - COORD_W default constant.
  - typedef vertex_t ([1:0][COORD_W-1:0]).
  - The state enum poly_state_t.
- One sub-module: line_walker.
  - Parametrised on COORD_W.
  - Interface: Load pulse, A, B, Step enable, X, Y, Last.
  - Holds the Bresenham registers.
- draw_polygon holds the FSM, latches, and edge sequencing.

Test Plan:
- Closed triangle (0,0),(4,0),(0,4), N=3 → 15 valid pixels, Done 22 cycles after Load. First pixel (0,0); edge 2 ends at (0,0). With POLY_SKIP_SHARED_EN → 12 pixels, each vertex once.
- Open polyline, same vertices, Closed=0 → 10 valid pixels; last pixel (0,4); Done after 1+7+7 = 15 cycles.
- N=0 → zero pixels, Done the cycle after Load. N=1 at (7,9) → exactly one pixel (7,9), then Done.
- Steep negative-slope edge (10,2)→(6,20), N=2 open → 19 pixels, y strictly increasing, x monotonically non-increasing, endpoints exact.
- Reset_n pulsed low mid-Draw of edge 1 → Pixel_Valid/Busy/Done drop to 0 asynchronously. After release, the state is Wait and there is no activity until a new Start.
- Start held high after Done for 5 cycles → Done stays 1 with no restart. Start low → Wait next cycle. Start again with N=9, MAX_VERTS=8 → clamped to 8 vertices.
